byte_assembler: RTL and testbench
=================================

// Module: byte_assembler
// PURPOSE
//   Serial-to-parallel front end for the 8-bit capture register stage.
//   - Shifts in qualified serial bits and assembles DATA_W-bit words.
//   - Presents each word on byte_out with a valid/ready handshake; the downstream register loads d from byte_out.
//   - Flags words lost because the consumer stalled (sticky overrun).
// PARAMETERS
//   DATA_W     8   word width in bits; legal range 2..32
//   MSB_FIRST  1   1: first received bit lands in byte_out[DATA_W-1]; 0: first bit lands in byte_out[0]
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high; clears all state
//   clr         in   1       synchronous clear; same effect as reset, on the clock edge
//   bit_in      in   1       serial data bit
//   bit_valid   in   1       bit_in is accepted on any edge where this is 1 (always accepted, no backpressure)
//   byte_out    out  DATA_W  assembled word
//   byte_valid  out  1       byte_out holds an unconsumed word
//   byte_ready  in   1       consumer accepts byte_out when byte_valid && byte_ready
//   bit_cnt     out  W       bits received in the current frame; W = $clog2(DATA_W+1)
//   overrun     out  1       sticky: a completed word was dropped
//   parity_err  out  1       parity result for the word on byte_out (see CONFIGURATION)
// BEHAVIOUR
//   Reset / clr values: byte_out=0, byte_valid=0, bit_cnt=0, overrun=0, parity_err=0, shift register=0.
//     - clr has priority over every other input in the same cycle.
//   Frame length: FL = DATA_W, or DATA_W+1 with PARITY_CHK_EN.
//   Shift path (independent of output state):
//     - bit_valid=1: shift bit_in into the shift register; bit_cnt+1.
//     - Completing bit (bit_cnt==FL-1 && bit_valid): bit_cnt wraps to 0 on the same edge; the word is complete.
//   Output FSM, two states:
//     - EMPTY (byte_valid=0):
//         word completes -> load byte_out; go FULL.
//     - FULL (byte_valid=1):
//         byte_ready=1, no completion -> go EMPTY; byte_out holds its last value.
//         byte_ready=1 and completion in the same cycle -> load the new word; stay FULL; no overrun.
//         byte_ready=0 and completion -> drop the new word; byte_out unchanged; overrun<=1; stay FULL.
//   Latency: byte_valid rises on the edge that accepts the completing bit, so it is visible the next cycle.
//   Throughput: one word per FL bit_valid cycles; back-to-back frames need no idle cycle.
//   byte_out and parity_err are stable whenever byte_valid=1 and the word has not been consumed.
//   overrun clears only on reset or clr.
//   reset asserted mid-frame: partial bits are discarded; the next accepted bit starts a new frame at bit_cnt=0.
//   byte_ready while EMPTY is ignored.
// CONFIGURATION
//   Macro PARITY_CHK_EN
//   Defined:
//     - Frame = DATA_W data bits followed by one even-parity bit (the parity bit is last, for both MSB_FIRST settings).
//     - parity_err loads together with byte_out: 1 if XOR(data bits, parity bit) != 0.
//     - A dropped word does not update parity_err.
//   Undefined:
//     - Frame = DATA_W bits.
//     - parity_err is tied to 0; the port remains present.
// TESTING
//   T1 reset: assert reset asynchronously mid-frame after 3 bits -> all outputs 0 immediately; next 8 bits 10100101 -> byte_out=8'hA5.
//   T2 order: MSB_FIRST=1, bits 1,1,0,0,0,0,0,1 with byte_ready=1 -> byte_out=8'hC1, byte_valid high exactly 1 cycle.
//   T3 order: MSB_FIRST=0, same bits -> byte_out=8'h83.
//   T4 stall: byte_ready=0; send 8'h3C then 8'hF0 -> byte_out stays 8'h3C, overrun=1; then byte_ready=1 -> byte_valid falls the next cycle.
//   T5 simultaneous: completing bit of 8'h55 on the same cycle byte_ready accepts 8'hAA -> byte_valid stays 1, byte_out=8'h55, overrun=0.
//   T6 parity (PARITY_CHK_EN): 8'h07 + parity 1 -> parity_err=0; 8'h07 + parity 0 -> parity_err=1; clr -> parity_err=0, bit_cnt=0.

Source files
------------

// File: rtl/byte_assembler_if.sv
// -----------------------------------------------------------------------------
// byte_assembler_if
//   Bundles the serial input, the word handshake and the status outputs of
//   byte_assembler.
//
//   Signals
//     bit_in      serial data bit                         (producer -> assembler)
//     bit_valid   bit_in qualifier, no backpressure       (producer -> assembler)
//     byte_ready  consumer accepts byte_out               (consumer -> assembler)
//     byte_out    assembled word, DATA_W bits             (assembler -> consumer)
//     byte_valid  byte_out holds an unconsumed word       (assembler -> consumer)
//     bit_cnt     bits received in the current frame      (assembler -> consumer)
//     overrun     sticky: a completed word was dropped    (assembler -> consumer)
//     parity_err  parity result for the word on byte_out  (assembler -> consumer)
//
//   Modports
//     slave   the assembler side
//     master  the side that drives bits / ready and watches the outputs
// -----------------------------------------------------------------------------
interface byte_assembler_if #(
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              bit_in;
    logic              bit_valid;
    logic              byte_ready;
    logic [DATA_W-1:0] byte_out;
    logic              byte_valid;
    logic [CNT_W-1:0]  bit_cnt;
    logic              overrun;
    logic              parity_err;

    modport slave (
        input  bit_in, bit_valid, byte_ready,
        output byte_out, byte_valid, bit_cnt, overrun, parity_err
    );

    modport master (
        output bit_in, bit_valid, byte_ready,
        input  byte_out, byte_valid, bit_cnt, overrun, parity_err
    );
endinterface

// File: rtl/byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
//   Serial-to-parallel front end: shifts in qualified serial bits, assembles
//   DATA_W-bit words and presents them with a valid/ready handshake. Words that
//   complete while the consumer is stalled are dropped and flagged by a sticky
//   overrun bit.
//
//   Parameters
//     DATA_W     word width (2..32)
//     MSB_FIRST  1: first bit received lands in byte_out[DATA_W-1]
//                0: first bit received lands in byte_out[0]
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-high reset, clears all state
//     clr        synchronous clear, same effect as reset, wins over all inputs
//     bus        byte_assembler_if.slave (bit_in, bit_valid, byte_ready in;
//                byte_out, byte_valid, bit_cnt, overrun, parity_err out)
//
//   Optional feature (macro PARITY_CHK_EN)
//     Defined:   each frame is DATA_W data bits followed by one even-parity bit;
//                parity_err loads with byte_out (1 = parity mismatch).
//     Undefined: frame is DATA_W bits; parity_err is constant 0.
// -----------------------------------------------------------------------------
module byte_assembler #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             reset,
    input logic             clr,
    byte_assembler_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef PARITY_CHK_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FL - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              par_q, par_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word;
    logic              word_par;
    logic              complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            par_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (clr) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            par_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            par_q   <= par_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        par_d    = par_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        if (MSB_FIRST) begin
            shifted = {shift_q[DATA_W-2:0], bus.bit_in};
        end else begin
            shifted = {bus.bit_in, shift_q[DATA_W-1:1]};
        end

`ifdef PARITY_CHK_EN
        // The completing bit is the parity bit: the data word is already
        // sitting in the shift register and parity covers data plus that bit.
        word     = shift_q;
        word_par = (^shift_q) ^ bus.bit_in;
`else
        // The completing bit is the last data bit, so take it from the
        // shifted value rather than waiting a cycle for the register.
        word     = shifted;
        word_par = 1'b0;
`endif

        // Shift path runs regardless of the output state. Shifting the parity
        // bit in is harmless: the next DATA_W bits overwrite the register.
        if (bus.bit_valid) begin
            shift_d = shifted;
            if (cnt_q == LAST_CNT) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            EMPTY: begin
                if (complete) begin
                    byte_d  = word;
                    par_d   = word_par;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.byte_ready) begin
                    if (complete) begin
                        // Old word leaves as the new one arrives: no loss.
                        byte_d = word;
                        par_d  = word_par;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (complete) begin
                    // Consumer stalled: keep the held word, drop the new one.
                    ovr_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = (state_q == FULL);
    assign bus.bit_cnt    = cnt_q;
    assign bus.overrun    = ovr_q;
    assign bus.parity_err = par_q;

endmodule

// File: tb/tb_byte_assembler.sv
// -----------------------------------------------------------------------------
// tb_byte_assembler
//   Directed bench for byte_assembler. Two instances share one bit stream:
//   dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0). Expected words are
//   hand-computed constants. Build with +define+PARITY_CHK_EN to exercise the
//   parity frame format.
// -----------------------------------------------------------------------------
module tb_byte_assembler;
    logic clk;
    logic reset;
    logic clr;
    int   checks;
    int   errors;

    byte_assembler_if #(.DATA_W(8)) bus_m ();
    byte_assembler_if #(.DATA_W(8)) bus_l ();

    byte_assembler #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus_m)
    );

    byte_assembler #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic r);
        bus_m.byte_ready = r;
        bus_l.byte_ready = r;
    endtask

    // One bit accepted on the next rising edge; returns 1 time unit after it.
    task automatic send_bit(input logic b);
        bus_m.bit_valid = 1'b1;
        bus_l.bit_valid = 1'b1;
        bus_m.bit_in    = b;
        bus_l.bit_in    = b;
        @(posedge clk);
        #1;
        bus_m.bit_valid = 1'b0;
        bus_l.bit_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sends w MSB-first in time; with parity enabled an even-parity bit
    // (optionally inverted) follows. If last_rdy_en, byte_ready is set to
    // last_rdy just before the completing bit.
    task automatic send_frame(input logic [7:0] w, input bit bad_par,
                              input bit last_rdy_en, input logic last_rdy);
        for (int i = 7; i >= 0; i--) begin
`ifndef PARITY_CHK_EN
            if (i == 0 && last_rdy_en) set_ready(last_rdy);
`endif
            send_bit(w[i]);
        end
`ifdef PARITY_CHK_EN
        if (last_rdy_en) set_ready(last_rdy);
        send_bit((^w) ^ bad_par);
`else
        if (bad_par) begin
            // no parity bit in this build
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clr    = 1'b0;
        bus_m.bit_in = 1'b0; bus_m.bit_valid = 1'b0; bus_m.byte_ready = 1'b0;
        bus_l.bit_in = 1'b0; bus_l.bit_valid = 1'b0; bus_l.byte_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_byte_out",   32'(bus_m.byte_out),   32'h0);
        chk("rst_byte_valid", 32'(bus_m.byte_valid), 32'h0);
        chk("rst_bit_cnt",    32'(bus_m.bit_cnt),    32'h0);
        chk("rst_overrun",    32'(bus_m.overrun),    32'h0);
        chk("rst_parity_err", 32'(bus_m.parity_err), 32'h0);
        reset = 1'b0;

        // T1: async reset mid-frame after 3 bits, then A5
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("t1_cnt_mid", 32'(bus_m.bit_cnt), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_cnt",   32'(bus_m.bit_cnt),    32'h0);
        chk("t1_async_valid", 32'(bus_m.byte_valid), 32'h0);
        #2 reset = 1'b0;
        set_ready(1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t1_byte_out_m", 32'(bus_m.byte_out),   32'hA5);
        chk("t1_byte_out_l", 32'(bus_l.byte_out),   32'hA5);
        chk("t1_valid",      32'(bus_m.byte_valid), 32'h1);
        chk("t1_cnt_wrap",   32'(bus_m.bit_cnt),    32'h0);

        // T2/T3: bit order, byte_valid for exactly one cycle with ready high
        send_frame(8'hC1, 1'b0, 1'b0, 1'b0);
        chk("t2_byte_out_m", 32'(bus_m.byte_out),   32'hC1);
        chk("t3_byte_out_l", 32'(bus_l.byte_out),   32'h83);
        chk("t2_valid_on",   32'(bus_m.byte_valid), 32'h1);
        idle_cycle();
        chk("t2_valid_off",  32'(bus_m.byte_valid), 32'h0);
        chk("t2_hold",       32'(bus_m.byte_out),   32'hC1);
        chk("t3_valid_off",  32'(bus_l.byte_valid), 32'h0);

        // T4: stall, second word dropped, sticky overrun
        set_ready(1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t4_first",      32'(bus_m.byte_out),   32'h3C);
        chk("t4_ovr_before", 32'(bus_m.overrun),    32'h0);
`ifndef PARITY_CHK_EN
        chk("t4_parity_tied", 32'(bus_m.parity_err), 32'h0);
`endif
        idle_cycle();
        chk("t4_valid_held", 32'(bus_m.byte_valid), 32'h1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("t4_kept",       32'(bus_m.byte_out),   32'h3C);
        chk("t4_kept_l",     32'(bus_l.byte_out),   32'h3C);
        chk("t4_overrun",    32'(bus_m.overrun),    32'h1);
        chk("t4_valid",      32'(bus_m.byte_valid), 32'h1);
        set_ready(1'b1);
        idle_cycle();
        chk("t4_valid_fall", 32'(bus_m.byte_valid), 32'h0);
        chk("t4_ovr_sticky", 32'(bus_m.overrun),    32'h1);

        // clr: clears everything and wins over a bit arriving the same edge
        set_ready(1'b0);
        clr = 1'b1;
        send_bit(1'b1);
        clr = 1'b0;
        chk("clr_overrun",  32'(bus_m.overrun),  32'h0);
        chk("clr_byte_out", 32'(bus_m.byte_out), 32'h0);
        chk("clr_bit_cnt",  32'(bus_m.bit_cnt),  32'h0);

        // T5: ready accepts AA on the same edge that completes 55
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        chk("t5_first", 32'(bus_m.byte_out), 32'hAA);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        chk("t5_valid",      32'(bus_m.byte_valid), 32'h1);
        chk("t5_byte_out_m", 32'(bus_m.byte_out),   32'h55);
        chk("t5_byte_out_l", 32'(bus_l.byte_out),   32'hAA);
        chk("t5_overrun",    32'(bus_m.overrun),    32'h0);
        idle_cycle();
        chk("t5_valid_off",  32'(bus_m.byte_valid), 32'h0);

`ifdef PARITY_CHK_EN
        // T6: parity
        set_ready(1'b1);
        send_frame(8'h07, 1'b0, 1'b0, 1'b0);
        chk("t6_good_word", 32'(bus_m.byte_out),   32'h07);
        chk("t6_good_par",  32'(bus_m.parity_err), 32'h0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        chk("t6_bad_par",   32'(bus_m.parity_err), 32'h1);
        idle_cycle();
        chk("t6_par_hold",  32'(bus_m.parity_err), 32'h1);
        send_bit(1'b1); send_bit(1'b0);
        clr = 1'b1;
        idle_cycle();
        clr = 1'b0;
        chk("t6_clr_par",   32'(bus_m.parity_err), 32'h0);
        chk("t6_clr_cnt",   32'(bus_m.bit_cnt),    32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
